// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-and-add mantissa product, fixed 26-cycle latency.
// Define FPMUL_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic        BUSY,
    output logic [1:0]  EXCEPTION
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef FPMUL_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic [1:0]         state;
    logic [4:0]         cnt;
    logic [23:0]        mcand;
    logic [23:0]        mplier;
    logic [47:0]        prod;
    logic [7:0]         exp_a;
    logic [7:0]         exp_b;
    logic               sign;
    logic               zero;

    logic signed [9:0]  exp_raw;
    logic signed [9:0]  exp_fin;
    logic [23:0]        rnd;
    logic [33:0]        res_nxt;

    // Returns {carry, mant[22:0]}; carry set only when rounding overflows the mantissa.
    function automatic logic [23:0] round_mant(input logic [47:0] p);
        logic [22:0] m;
        logic        g;
        logic        s;
        if (p[47]) begin
            m = p[46:24];
            g = p[23];
            s = |p[22:0];
        end else begin
            m = p[45:23];
            g = p[22];
            s = |p[21:0];
        end
        return {1'b0, m} + {23'd0, ROUND_EN & g & (s | m[0])};
    endfunction

    // Returns {exception, result}.
    function automatic logic [33:0] saturate(input logic sgn, input logic signed [9:0] e,
                                             input logic [22:0] m);
        if (e >= 10'sd255)
            return {2'b10, sgn, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {2'b01, sgn, 31'd0};
        else
            return {2'b00, sgn, e[7:0], m};
    endfunction

    always_comb begin
        exp_raw = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127
                  + $signed({9'd0, prod[47]});
        rnd     = round_mant(prod);
        exp_fin = exp_raw + $signed({9'd0, rnd[23]});
        res_nxt = zero ? {2'b00, sign, 31'd0} : saturate(sign, exp_fin, rnd[22:0]);
    end

    assign DONE = (state == S_DONE);
    assign BUSY = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            mcand     <= 24'd0;
            mplier    <= 24'd0;
            prod      <= 48'd0;
            exp_a     <= 8'd0;
            exp_b     <= 8'd0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            AxB       <= 32'd0;
            EXCEPTION <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand     <= {1'b1, InputA[22:0]};
                        mplier    <= {1'b1, InputB[22:0]};
                        exp_a     <= InputA[30:23];
                        exp_b     <= InputB[30:23];
                        sign      <= InputA[31] ^ InputB[31];
                        zero      <= (InputA[30:23] == 8'd0) || (InputB[30:23] == 8'd0);
                        prod      <= 48'd0;
                        cnt       <= 5'd0;
                        AxB       <= 32'd0;
                        EXCEPTION <= 2'b00;
                        state     <= S_MULT;
                    end
                end
                S_MULT: begin
                    // One multiplier bit per cycle; the 25th MULT cycle only hands over to NORM.
                    if (cnt == 5'd24) begin
                        state <= S_NORM;
                    end else begin
                        if (mplier[0])
                            prod <= prod + ({24'd0, mcand} << cnt);
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 5'd1;
                    end
                end
                S_NORM: begin
                    {EXCEPTION, AxB} <= res_nxt;
                    state            <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed corner cases plus random operands against an arithmetic reference model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] InputA;
    logic [31:0] InputB;
    logic [31:0] AxB;
    logic        DONE;
    logic        BUSY;
    logic [1:0]  EXCEPTION;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .InputA    (InputA),
        .InputB    (InputB),
        .AxB       (AxB),
        .DONE      (DONE),
        .BUSY      (BUSY),
        .EXCEPTION (EXCEPTION)
    );

    always #5 clk = ~clk;

`ifdef FPMUL_ROUND_EN
    localparam bit ROUND = 1'b1;
    localparam logic [31:0] R031 = 32'h40100002;
`else
    localparam bit ROUND = 1'b0;
    localparam logic [31:0] R031 = 32'h40100001;
`endif

    typedef struct {
        logic [31:0] axb;
        logic [1:0]  exc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   errors    = 0;
    int   checks    = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product, rounding decided by comparing the discarded part to one half.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p, mant, rem, half;
        int e;
        logic s;
        bit rnd_up;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {2'b00, s, 31'd0};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= 64'h8000_0000_0000) begin
            e++;
            mant = p / 64'd16777216 - 64'd8388608;
            rem  = p % 64'd16777216;
            half = 64'd8388608;
        end else begin
            mant = p / 64'd8388608 - 64'd8388608;
            rem  = p % 64'd8388608;
            half = 64'd4194304;
        end
        rnd_up = (rem > half) || (rem == half && mant % 2 == 1);
        if (ROUND && rnd_up) begin
            mant++;
            if (mant == 64'd8388608) begin
                mant = 0;
                e++;
            end
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, 8'(e), 23'(mant)};
    endfunction

    // Monitor: pops one expectation per DONE pulse.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (DONE === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 want no DONE (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("axb", {2'b00, AxB}, {2'b00, mon_e.axb});
                chk("exception", {32'd0, EXCEPTION}, {32'd0, mon_e.exc});
                chk("latency", 34'(cyc - mon_e.cyc), 34'd26);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ex_axb, input logic [1:0] ex_exc);
        @(negedge clk);
        InputA = a;
        InputB = b;
        start  = 1'b1;
        sb.push_back('{ex_axb, ex_exc, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {33'd0, BUSY}, 34'd1);
        chk("cleared_after_accept", {EXCEPTION, AxB}, 34'd0);
        InputA = $urandom;
        InputB = $urandom;
    endtask

    task automatic wait_done(input int n, input logic [31:0] ex_axb, input logic [1:0] ex_exc);
        for (int i = 0; i < 40 && done_seen == n; i++) @(negedge clk);
        if (done_seen == n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE want DONE within 40 cycles");
        end else begin
            repeat (3) @(negedge clk);
            chk("hold_after_done", {EXCEPTION, AxB}, {ex_exc, ex_axb});
            chk("idle_after_done", {33'd0, BUSY}, 34'd0);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ex_axb, input logic [1:0] ex_exc);
        int n;
        n = done_seen;
        issue(a, b, ex_axb, ex_exc);
        wait_done(n, ex_axb, ex_exc);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [33:0] m;
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        InputA = 32'd0;
        InputB = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {DONE, BUSY, EXCEPTION, AxB}, 36'd0);
        rst_n = 1'b1;

        run_op(32'h40000000, 32'h40400000, 32'h40C00000, 2'b00);
        run_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 2'b00);
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00);
        run_op(32'h3FC00001, 32'h3FC00001, R031, 2'b00);
        run_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b10);
        run_op(32'h00800000, 32'h00800000, 32'h00000000, 2'b01);
        run_op(32'h00000000, 32'h40400000, 32'h00000000, 2'b00);
        run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b10);

        // A start pulse during the operation must be ignored.
        n = done_seen;
        issue(32'h40000000, 32'h40400000, 32'h40C00000, 2'b00);
        repeat (4) @(negedge clk);
        InputA = 32'h3F800000;
        InputB = 32'h3F800000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, 32'h40C00000, 2'b00);
        chk("single_done_for_ignored_start", 34'(done_seen - n), 34'd1);

        // Reset mid-operation abandons it; start on the first edge after release is accepted.
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", {DONE, BUSY, EXCEPTION, AxB}, 36'd0);
        sb.delete();
        n = done_seen;
        repeat (3) @(negedge clk);
        chk("no_done_in_reset", 34'(done_seen - n), 34'd0);
        rst_n  = 1'b1;
        InputA = 32'hC0000000;
        InputB = 32'h3F000000;
        start  = 1'b1;
        sb.push_back('{32'hBF800000, 2'b00, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_first_edge_after_reset", {33'd0, BUSY}, 34'd1);
        wait_done(n, 32'hBF800000, 2'b00);
        chk("one_done_after_reset", 34'(done_seen - n), 34'd1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 9) == 0) a[30:23] = 8'd0;
            if ($urandom_range(0, 9) == 0) b[30:23] = 8'd0;
            if ($urandom_range(0, 3) == 0) a[30:23] = 8'($urandom_range(100, 160));
            if ($urandom_range(0, 3) == 0) b[30:23] = 8'($urandom_range(100, 160));
            m = model(a, b);
            run_op(a, b, m[31:0], m[33:32]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 34'(sb.size()), 34'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have start  input  1  request; accepted only in IDLE.
REQ-004 SHALL have InputA  input  32  IEEE-754 single multiplicand.
REQ-005 SHALL have InputB  input  32  IEEE-754 single multiplier.
REQ-006 SHALL have AxB  output  32  product {sign,exp[7:0],mant[22:0]}.
REQ-007 SHALL have DONE  output  1  one-cycle pulse; AxB/EXCEPTION valid.
REQ-008 SHALL have BUSY  output  1  high from accept until DONE cycle inclusive.
REQ-009 SHALL have EXCEPTION  output  2  00 none, 10 overflow, 01 underflow.

Function
REQ-010 SHALL implement states IDLE, MULT, NORM, DONE; IDLE->MULT on start; MULT->NORM after 24 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-011 SHALL register InputA/InputB on the accepting edge; later input changes SHALL not affect the operation.
REQ-012 SHALL ignore start while BUSY is high; no queuing.
REQ-013 SHALL compute the 48-bit mantissa product {1,mantA}*{1,mantB} by shift-and-add, one multiplier bit per cycle in MULT.
REQ-014 SHALL fix latency: DONE high exactly 26 cycles after the accepting edge, for every operand, including zero operands.
REQ-015 SHALL compute sign = InputA[31] XOR InputB[31].
REQ-016 SHALL compute biased exponent in 10-bit signed arithmetic: expA + expB - 127, plus 1 when product bit 47 is set.
REQ-017 SHALL normalise in NORM: bit47 set -> mant = product[46:24]; else mant = product[45:23].
REQ-018 SHALL treat any operand with exponent field 0 as zero: result {sign,31'b0}, EXCEPTION 00.
REQ-019 SHALL not decode exponent 255 specially; it is an ordinary exponent.
REQ-020 SHALL, when biased exponent >= 255, output {sign,8'hFF,23'b0} with EXCEPTION 10.
REQ-021 SHALL, when biased exponent <= 0 and no operand is zero, output {sign,31'b0} with EXCEPTION 01.
REQ-022 SHALL hold AxB and EXCEPTION stable from DONE until the next accepted start.
REQ-023 SHALL clear AxB and EXCEPTION to 0 on the cycle after a start is accepted.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, AxB 0, DONE 0, BUSY 0, EXCEPTION 00, and clear internal product/counter.
REQ-025 SHALL abandon any in-flight operation on reset without emitting DONE.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with FPMUL_ROUND_EN defined, round to nearest-even using guard and sticky bits below the kept mantissa; mantissa carry-out SHALL increment the exponent before the overflow check.
REQ-028 SHALL, with FPMUL_ROUND_EN undefined, truncate; latency is unchanged either way.

Verification
REQ-029 SHALL check 0x40000000 x 0x40400000 -> AxB 0x40C00000, EXCEPTION 00, DONE 26 cycles after start.
REQ-030 SHALL check 0xC0000000 x 0x3F000000 -> 0xBF800000; and 0x3FC00000 x 0x3FC00000 -> 0x40100000 (normalisation shift).
REQ-031 SHALL check 0x3FC00001 x 0x3FC00001 -> 0x40100001 without FPMUL_ROUND_EN, 0x40100002 with it.
REQ-032 SHALL check 0x7F000000 x 0x7F000000 -> 0x7F800000, EXCEPTION 10; 0x00800000 x 0x00800000 -> 0x00000000, EXCEPTION 01.
REQ-033 SHALL check 0x00000000 x 0x40400000 -> 0x00000000, EXCEPTION 00, latency 26.
REQ-034 SHALL check start pulsed at cycle 5 of an operation is ignored, and rst_n low at cycle 10 gives BUSY 0 immediately and no DONE.
